// File: rtl/tick_gen_pkg.sv
// Package for the tick generator: defaults and limits shared by tick_gen and
// tick_chan, sourced from the common defs include.
package tick_gen_pkg;
`include "tick_gen_defs.vh"

  localparam int CLK_HZ_DEF = `TICK_GEN_CLK_HZ;
  localparam int MAX_CH     = `TICK_GEN_MAX_CH;
  localparam int SEL_W      = `TICK_GEN_SEL_W;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: free-running divide-by-D counter with a shadowed divisor
// that is only applied at a period boundary (wrap) or on clear.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int DIV_W  = 24
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUN,
  input  logic             CLR,
  input  logic             LD,
  input  logic [DIV_W-1:0] LD_VAL,
  output logic             ENABLE,
  output logic             SQW,
  output logic             PEND
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(CLK_HZ);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_shd;
  logic [DIV_W-1:0] ld_eff;
  logic             sqw_q;
  logic             pend_q;
  logic             wrap;

  // A divisor of 0 would never wrap; it behaves as 1 (tick every cycle).
  assign ld_eff = (LD_VAL == '0) ? ONE : LD_VAL;
  assign wrap   = (cnt == div_act - ONE);

  assign ENABLE = !RESET && RUN && !CLR && wrap;
  assign SQW    = sqw_q;
  assign PEND   = pend_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt     <= '0;
      div_act <= RST_DIV;
      div_shd <= RST_DIV;
      pend_q  <= 1'b0;
      sqw_q   <= 1'b0;
    end else begin
      if (CLR) begin
        cnt   <= '0;
        sqw_q <= 1'b0;
        if (pend_q) begin
          div_act <= div_shd;
          pend_q  <= 1'b0;
        end
      end else if (RUN) begin
        if (wrap) begin
          cnt   <= '0;
          sqw_q <= ~sqw_q;
          if (pend_q) begin
            div_act <= div_shd;
            pend_q  <= 1'b0;
          end
        end else begin
          cnt <= cnt + ONE;
        end
      end
      // A load on the applying edge lands in the shadow and waits for the next boundary.
      if (LD) begin
        div_shd <= ld_eff;
        pend_q  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_gen_defs.vh
// Shared constants for the tick generator: default clock rate, channel ceiling,
// and the width of the divisor-load channel index.
`ifndef TICK_GEN_DEFS_VH
`define TICK_GEN_DEFS_VH
`define TICK_GEN_CLK_HZ 12000000
`define TICK_GEN_MAX_CH 8
`define TICK_GEN_SEL_W  3
`endif

// File: rtl/tick_gen.sv
// Multi-channel tick generator: decodes divisor loads and hosts N_CH
// independent tick_chan instances.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int N_CH   = 4,
  parameter int DIV_W  = 24
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_CH-1:0]  RUN,
  input  logic [N_CH-1:0]  CLR,
  input  logic             DIV_LD,
  input  logic [SEL_W-1:0] DIV_SEL,
  input  logic [DIV_W-1:0] DIV_VAL,
  output logic [N_CH-1:0]  ENABLE,
  output logic [N_CH-1:0]  SQW,
  output logic [N_CH-1:0]  PEND
);

  // DIV_LD is a single-cycle strobe with no backpressure: DIV_SEL/DIV_VAL are
  // taken on the strobe edge, and an out-of-range DIV_SEL matches no channel.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    if (i < MAX_CH) begin : g_live
      logic ld;
      assign ld = DIV_LD && (DIV_SEL == SEL_W'(i));

      tick_chan #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W)
      ) u_chan (
        .CLK    (CLK),
        .RESET  (RESET),
        .RUN    (RUN[i]),
        .CLR    (CLR[i]),
        .LD     (ld),
        .LD_VAL (DIV_VAL),
        .ENABLE (ENABLE[i]),
        .SQW    (SQW[i]),
        .PEND   (PEND[i])
      );
    end else begin : g_none
      assign ENABLE[i] = 1'b0;
      assign SQW[i]    = 1'b0;
      assign PEND[i]   = 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen (CLK_HZ=20, N_CH=4, DIV_W=8): a cycle-schedule
// model checks every output each cycle, plus hand-computed tick cycle lists.
module tb_tick_gen;

  localparam int CLK_HZ   = 20;
  localparam int N_CH     = 4;
  localparam int DIV_W    = 8;
  localparam int LAST_CYC = 130;

  logic             CLK = 1'b1;
  logic             RESET;
  logic [N_CH-1:0]  RUN;
  logic [N_CH-1:0]  CLR;
  logic             DIV_LD;
  logic [2:0]       DIV_SEL;
  logic [DIV_W-1:0] DIV_VAL;
  logic [N_CH-1:0]  ENABLE;
  logic [N_CH-1:0]  SQW;
  logic [N_CH-1:0]  PEND;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = -2;
  bit active   = 1'b1;

  // Hand-computed tick cycles (release edge ends cycle 1).
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q3[$];

  // Model: absolute cycle of each channel's next tick, plus divisor bookkeeping.
  int m_d[N_CH];
  int m_s[N_CH];
  int m_next[N_CH];
  int m_nticks[N_CH];
  bit m_pend[N_CH];

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .N_CH   (N_CH),
    .DIV_W  (DIV_W)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .RUN     (RUN),
    .CLR     (CLR),
    .DIV_LD  (DIV_LD),
    .DIV_SEL (DIV_SEL),
    .DIV_VAL (DIV_VAL),
    .ENABLE  (ENABLE),
    .SQW     (SQW),
    .PEND    (PEND)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int c);
    RESET   = (c <= 0);
    RUN     = 4'b1111;
    CLR     = 4'b0000;
    DIV_LD  = 1'b0;
    DIV_SEL = 3'd0;
    DIV_VAL = 8'd0;
    if (c >= 11 && c <= 17) RUN[3] = 1'b0;
    if (c == 15)  CLR[2] = 1'b1;
    if (c == 100) CLR[0] = 1'b1;
    case (c)
      -1: begin DIV_LD = 1'b1; DIV_SEL = 3'd0; DIV_VAL = 8'd7; end
      8:  begin DIV_LD = 1'b1; DIV_SEL = 3'd1; DIV_VAL = 8'd5; end
      10: begin DIV_LD = 1'b1; DIV_SEL = 3'd5; DIV_VAL = 8'd3; end
      12: begin DIV_LD = 1'b1; DIV_SEL = 3'd2; DIV_VAL = 8'd0; end
      default: ;
    endcase
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge CLK) begin : cmp
    logic [N_CH-1:0] e_en;
    logic [N_CH-1:0] e_sqw;
    logic [N_CH-1:0] e_pend;
    if (active) begin
      for (int i = 0; i < N_CH; i++) begin
        e_en[i]   = !RESET && RUN[i] && !CLR[i] && (cyc == m_next[i]);
        e_sqw[i]  = (m_nticks[i] % 2) == 1;
        e_pend[i] = m_pend[i];
      end
      // Registers are unknown until the first reset edge.
      if (cyc >= -1) begin
        check("enable", ENABLE, e_en);
        check("sqw", SQW, e_sqw);
        check("pend", PEND, e_pend);
      end

      if (!RESET) begin
        if (ENABLE[0]) begin
          if (exp_q0.size() == 0) check("tick0_extra", cyc, 32'hFFFF);
          else check("tick0_cycle", cyc, exp_q0.pop_front());
        end
        if (ENABLE[1]) begin
          if (exp_q1.size() == 0) check("tick1_extra", cyc, 32'hFFFF);
          else check("tick1_cycle", cyc, exp_q1.pop_front());
        end
        if (ENABLE[3]) begin
          if (exp_q3.size() == 0) check("tick3_extra", cyc, 32'hFFFF);
          else check("tick3_cycle", cyc, exp_q3.pop_front());
        end
      end

      if (cyc == 20)  check("sqw0_c20", SQW[0], 1'b0);
      if (cyc == 21)  check("sqw0_c21", SQW[0], 1'b1);
      if (cyc == 40)  check("sqw0_c40", SQW[0], 1'b1);
      if (cyc == 41)  check("sqw0_c41", SQW[0], 1'b0);
      if (cyc == 101) check("sqw0_after_clr", SQW[0], 1'b0);
      if (cyc == 100) check("en0_clr_cycle", ENABLE[0], 1'b0);
      if (cyc == 8)   check("pend1_c8", PEND[1], 1'b0);
      if (cyc == 9)   check("pend1_c9", PEND[1], 1'b1);
      if (cyc == 20)  check("pend1_c20", PEND[1], 1'b1);
      if (cyc == 21)  check("pend1_c21", PEND[1], 1'b0);
      if (cyc == 15)  check("en2_clr_cycle", ENABLE[2], 1'b0);
      if (cyc == 16)  check("en2_c16", ENABLE[2], 1'b1);
      if (cyc == 50)  check("en2_c50", ENABLE[2], 1'b1);

      // Advance the model through this cycle's closing edge.
      for (int i = 0; i < N_CH; i++) begin
        if (RESET) begin
          m_d[i]      = CLK_HZ;
          m_s[i]      = CLK_HZ;
          m_pend[i]   = 1'b0;
          m_nticks[i] = 0;
          m_next[i]   = cyc + CLK_HZ;
        end else begin
          if (CLR[i]) begin
            if (m_pend[i]) begin m_d[i] = m_s[i]; m_pend[i] = 1'b0; end
            m_next[i]   = cyc + m_d[i];
            m_nticks[i] = 0;
          end else if (!RUN[i]) begin
            m_next[i]++;
          end else if (cyc == m_next[i]) begin
            if (m_pend[i]) begin m_d[i] = m_s[i]; m_pend[i] = 1'b0; end
            m_next[i] = cyc + m_d[i];
            m_nticks[i]++;
          end
          if (DIV_LD && (int'(DIV_SEL) == i)) begin
            m_s[i]    = (DIV_VAL == 0) ? 1 : int'(DIV_VAL);
            m_pend[i] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- sequence + report ----------------
  initial begin
    exp_q0 = '{16'd20, 16'd40, 16'd60, 16'd80, 16'd120};
    exp_q1.push_back(16'd20);
    for (int t = 25; t <= LAST_CYC; t += 5) exp_q1.push_back(16'(t));
    exp_q3 = '{16'd27, 16'd47, 16'd67, 16'd87, 16'd107, 16'd127};

    for (int c = -2; c <= LAST_CYC; c++) begin
      cyc = c;
      drive(c);
      @(posedge CLK);
      #1;
    end
    active = 1'b0;

    check("tick0_missing", exp_q0.size(), 0);
    check("tick1_missing", exp_q1.size(), 0);
    check("tick3_missing", exp_q3.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
